// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch front end: NOP encoding and queue entry width.
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // A queue entry carries {pc, instruction}.
  function automatic int fetch_entry_w(input int xlen);
    return 2 * xlen;
  endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Registered FIFO with push/pop/clear, occupancy count and empty/full flags.
module sync_fifo
  import fetch_queue_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = storage[rd_ptr];

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !clear && do_push) storage[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: in-order requests, PC-tagged response queue,
// and redirect handling that drops responses still in flight.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirectPc,
  output logic            reqValid,
  input  logic            reqReady,
  output logic [XLEN-1:0] pcOut,
  input  logic            respValid,
  input  logic [XLEN-1:0] instr,
  output logic            deqValid,
  input  logic            deqReady,
  output logic [XLEN-1:0] deqInstr,
  output logic [XLEN-1:0] deqPc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = fetch_entry_w(XLEN);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] redirect_base;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            req_fire;
  logic            resp_take;
  logic            push;
  logic            pop;
  logic            empty;
  logic            full;
  logic [EW-1:0]   head;

  assign redirect_base = {redirectPc[XLEN-1:2], 2'b00};
  assign occupancy     = {1'b0, count} + {1'b0, inflight};

  assign reqValid  = rst && !redirect && !full && (occupancy < (CW+1)'(DEPTH));
  assign pcOut     = fetch_pc;
  assign req_fire  = reqValid && reqReady;
  assign resp_take = respValid && (inflight != '0);

  // A response that arrives alongside a redirect is stale and never enters the queue.
  assign push = rst && !redirect && resp_take && (drop_cnt == '0);

  assign deqValid = rst && !redirect && !empty;
  assign pop      = deqValid && deqReady;
  assign deqPc    = head[EW-1:XLEN];
  assign deqInstr = deqValid ? head[XLEN-1:0] : XLEN'(NOP_INSTR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_base;
      resp_pc  <= redirect_base;
      inflight <= inflight - CW'(resp_take);
      drop_cnt <= inflight - CW'(resp_take);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      inflight <= inflight + CW'(req_fire) - CW'(resp_take);
      if (resp_take) begin
        if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        else                resp_pc  <= resp_pc + XLEN'(4);
      end
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({resp_pc, instr}),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: in-order memory model with epochs for
// redirect/reset, and a scoreboard of expected {pc, instr} checked by a monitor.
module tb_fetch_queue;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 4;
  localparam int CYCLES = 3000;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] pcOut;
  logic        respValid;
  logic [31:0] instr;
  logic        deqValid;
  logic        deqReady;
  logic [31:0] deqInstr;
  logic [31:0] deqPc;

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          ready;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  req_t mem_q[$];
  ent_t sb[$];
  ent_t landing[$];

  int          compared   = 0;
  int          mismatched = 0;
  int          cycle      = 0;
  int          epoch      = 0;
  int          last_ready = 0;
  bit          started    = 0;
  bit          prev_reset = 0;
  logic [31:0] exp_fetch  = RESET_PC;

  fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .pcOut      (pcOut),
    .respValid  (respValid),
    .instr      (instr),
    .deqValid   (deqValid),
    .deqReady   (deqReady),
    .deqInstr   (deqInstr),
    .deqPc      (deqPc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction word the memory holds at a given address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s (cycle %0d): got %h expected %h", name, cycle, act, exp);
    end
  endtask

  // Drive one cycle's inputs; traffic mix depends on the phase of the run.
  task automatic applyStimulus(input int cyc);
    int lat_ok;
    rst        = !(cyc <= 3 || (cyc > 20 && $urandom_range(299, 0) == 0));
    redirect   = 1'b0;
    redirectPc = $urandom;
    respValid  = 1'b0;
    instr      = $urandom;
    if (cyc < 400) begin
      reqReady = 1'b1;
      deqReady = 1'b1;
    end else if (cyc < 800) begin
      reqReady = 1'b1;
      deqReady = ($urandom_range(4, 0) == 0);
    end else begin
      reqReady = ($urandom_range(3, 0) != 0);
      deqReady = ($urandom_range(2, 0) != 0);
    end
    if (!rst) return;
    if ($urandom_range(cyc < 800 ? 39 : 11, 0) == 0) begin
      redirect   = 1'b1;
      redirectPc = ($urandom_range(5, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                : ($urandom & 32'h0000_0FFF);
    end
    lat_ok = (mem_q.size() > 0) ? int'(mem_q[0].ready <= cyc) : 0;
    if (lat_ok != 0 && (cyc < 800 || $urandom_range(3, 0) != 0)) begin
      respValid = 1'b1;
      instr     = memWord(mem_q[0].addr);
    end else if (mem_q.size() == 0 && cyc >= 800 && $urandom_range(7, 0) == 0) begin
      respValid = 1'b1;
    end
  endtask

  // Stimulus and reference model: one iteration per clock cycle.
  initial begin
    req_t r;
    ent_t e;
    int   lat;
    rst = 1'b0; redirect = 1'b0; redirectPc = '0; reqReady = 1'b0;
    respValid = 1'b0; instr = '0; deqReady = 1'b0;
    for (int c = 1; c <= CYCLES; c++) begin
      @(negedge clk);
      cycle = c;
      while (landing.size() > 0) sb.push_back(landing.pop_front());
      applyStimulus(c);
      if (c >= 2) started = 1;
      #1;
      if (!rst) begin
        checkOutput("reqValid_in_reset", 32'(reqValid), 32'd0);
        if (prev_reset) checkOutput("pcOut_in_reset", pcOut, RESET_PC);
        mem_q.delete();
        sb.delete();
        landing.delete();
        epoch++;
        last_ready = 0;
        exp_fetch  = RESET_PC;
        prev_reset = 1;
        continue;
      end
      prev_reset = 0;
      checkOutput("reqValid", 32'(reqValid),
                  32'(!redirect && (sb.size() + mem_q.size() < DEPTH)));
      if (reqValid) checkOutput("pcOut", pcOut, exp_fetch);
      if (respValid && mem_q.size() > 0) begin
        r = mem_q.pop_front();
        if (!redirect && r.ep == epoch) begin
          e.pc  = r.addr;
          e.ins = memWord(r.addr);
          landing.push_back(e);
        end
      end
      if (reqValid && reqReady && !redirect) begin
        lat        = (c < 800) ? 1 : $urandom_range(4, 1);
        r.addr     = exp_fetch;
        r.ep       = epoch;
        r.ready    = (c + lat > last_ready) ? c + lat : last_ready;
        last_ready = r.ready;
        mem_q.push_back(r);
        exp_fetch  = exp_fetch + 32'd4;
      end
      if (redirect) begin
        sb.delete();
        landing.delete();
        epoch++;
        exp_fetch = {redirectPc[31:2], 2'b00};
      end
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Monitor: checks deq handshake and pops the scoreboard on every accepted instruction.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (started) begin
        checkOutput("deqValid", 32'(deqValid), 32'(rst && !redirect && sb.size() != 0));
        checkOutput("count_bound", 32'(dut.u_fifo.count <= DEPTH), 32'd1);
        if (deqValid && deqReady && sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("deqPc", deqPc, e.pc);
          checkOutput("deqInstr", deqInstr, e.ins);
        end
      end
    end
  end

endmodule
